// File: rtl/shake256_absorb_packer_pkg.sv
// Shared definitions for the SHAKE256 absorb-side packer: rate geometry,
// packer state encoding and the block byte-position helper.
package shake256_pkg;

  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned RATE_BITS  = 1088;
  localparam int unsigned LEN_W      = 11;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    EMIT_EMPTY = 2'd2
  } state_t;

  // MSB index of block byte k (byte 0 sits in the top bits).
  function automatic int unsigned byte_offset(input int unsigned k);
    return RATE_BITS - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/shake256_absorb_packer_beat_writer.sv
// Inserts one 8-byte beat at byte position cnt of the rate buffer; beat
// bytes at or beyond n are written as zero.
module shake256_beat_writer
  import shake256_pkg::*;
(
  input  logic [RATE_BITS-1:0] blk,
  input  logic [63:0]          beat,
  input  logic [3:0]           n,
  input  logic [7:0]           cnt,
  output logic [RATE_BITS-1:0] blk_next
);

  always_comb begin
    blk_next = blk;
    for (int unsigned i = 0; i < 8; i++) begin
      if (32'(cnt) + i < RATE_BYTES) begin
        blk_next[byte_offset(32'(cnt) + i) -: 8] = (i < 32'(n)) ? beat[63 - 8 * i -: 8] : 8'h00;
      end
    end
  end

endmodule

// File: rtl/shake256_absorb_packer.sv
// Packs a byte stream of 64-bit beats into 1088-bit SHAKE256 rate blocks and
// ensures the final block handed to the core is always shorter than the rate.
module shake256_absorb_packer #(
  parameter int unsigned RATE_BYTES = 136,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [8*BEAT_BYTES-1:0]   in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [3:0]                in_bytes,
  output logic                      in_ready,
  output logic [8*RATE_BYTES-1:0]   out_block,
  output logic [10:0]               out_length,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  import shake256_pkg::*;

  localparam logic [7:0] RATE_CNT  = 8'(RATE_BYTES);
  localparam logic [3:0] BEAT_CNT  = 4'(BEAT_BYTES);

  state_t                  state, state_next;
  logic [7:0]              cnt, cnt_next;
  logic [8*RATE_BYTES-1:0] blk, blk_next, blk_written;
  logic                    pend_empty, pend_next;
  logic                    last_flag, last_next;
  logic [3:0]              n;
  logic [7:0]              sum;

  always_comb begin
    n = BEAT_CNT;
    if (in_last) begin
      n = (in_bytes > BEAT_CNT) ? BEAT_CNT : in_bytes;
    end
  end

  assign sum = cnt + 8'(n);

  shake256_beat_writer u_writer (
    .blk      (blk),
    .beat     (in_data),
    .n        (n),
    .cnt      (cnt),
    .blk_next (blk_written)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      cnt        <= '0;
      blk        <= '0;
      pend_empty <= 1'b0;
      last_flag  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      blk        <= blk_next;
      pend_empty <= pend_next;
      last_flag  <= last_flag == last_next ? last_flag : last_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    blk_next   = blk;
    pend_next  = pend_empty;
    last_next  = last_flag;
    case (state)
      FILL: begin
        if (in_valid) begin
          blk_next = blk_written;
          cnt_next = sum;
          if (sum == RATE_CNT || in_last) begin
            state_next = EMIT;
            // An exactly-full final block is not final: an empty block follows.
            last_next  = in_last && (sum != RATE_CNT);
            pend_next  = in_last && (sum == RATE_CNT);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          blk_next   = '0;
          cnt_next   = '0;
          state_next = pend_empty ? EMIT_EMPTY : FILL;
        end
      end
      EMIT_EMPTY: begin
        if (out_ready) begin
          pend_next  = 1'b0;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign in_ready   = (state == FILL);
  assign out_valid  = (state != FILL);
  assign out_block  = (state == EMIT) ? blk : '0;
  assign out_length = (state == EMIT) ? {cnt, 3'b000} : '0;
  assign out_last   = (state == EMIT_EMPTY) || ((state == EMIT) && last_flag);

endmodule

// File: tb/tb_shake256_absorb_packer.sv
// Randomized bench for shake256_absorb_packer: a message-level model splits
// each message into expected rate blocks that a compare process checks.
module tb_shake256_absorb_packer;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [1087:0] data;
    int unsigned   len;
    bit            last;
  } blk_t;

  logic          clock;
  logic          reset;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic [1087:0] out_block;
  logic [10:0]   out_length;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  shake256_absorb_packer #(
    .RATE_BYTES (136),
    .BEAT_BYTES (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .in_ready   (in_ready),
    .out_block  (out_block),
    .out_length (out_length),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          rdy_mode = 1;
  blk_t        exp_q[$];
  blk_t        mdl_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [1087:0] act, input logic [1087:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      for (int unsigned k = 0; k < 136; k++) begin
        if (act[1087 - 8 * k -: 8] !== req[1087 - 8 * k -: 8]) begin
          $display("FAIL %s: first bad byte %0d got %h, expected %h (t=%0t)",
                   nm, k, act[1087 - 8 * k -: 8], req[1087 - 8 * k -: 8], $time);
          break;
        end
      end
    end
  endtask

  // Message-level model: full 136-byte chunks, then a final short block
  // (an empty one when the message length is a nonzero multiple of 136).
  function automatic void model(input bq_t m);
    int unsigned L, full, r;
    blk_t e;
    mdl_q.delete();
    L    = m.size();
    full = L / 136;
    r    = L % 136;
    for (int unsigned b = 0; b < full; b++) begin
      e.data = '0;
      for (int unsigned k = 0; k < 136; k++) e.data[1087 - 8 * k -: 8] = m[b * 136 + k];
      e.len  = 1088;
      e.last = 1'b0;
      mdl_q.push_back(e);
    end
    e.data = '0;
    for (int unsigned k = 0; k < r; k++) e.data[1087 - 8 * k -: 8] = m[full * 136 + k];
    e.len  = 8 * r;
    e.last = 1'b1;
    mdl_q.push_back(e);
  endfunction

  function automatic bq_t make_const(input int unsigned L, input byte unsigned v);
    bq_t m;
    for (int unsigned i = 0; i < L; i++) m.push_back(v);
    return m;
  endfunction

  function automatic bq_t make_rand(input int unsigned L);
    bq_t m;
    for (int unsigned i = 0; i < L; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input int unsigned nbytes);
    logic acc;
    int   guard;
    in_data  = d;
    in_last  = last;
    in_bytes = 4'($urandom);
    if (last) begin
      in_bytes = 4'(nbytes);
      if (nbytes == 8 && ($urandom % 2) == 1) in_bytes = 4'($urandom_range(9, 15));
    end
    in_valid = 1'b1;
    guard    = 0;
    forever begin
      acc = in_ready;
      @(posedge clock);
      #1;
      if (acc) break;
      guard++;
      if (guard > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", guard);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "accept timeout");
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_msg(input bq_t m);
    int unsigned L, nb, nbytes;
    logic [63:0] d;
    L = m.size();
    model(m);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    nb = (L == 0) ? 1 : (L + 7) / 8;
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        d[63 - 8 * i -: 8] = (8 * b + i < L) ? m[8 * b + i] : 8'($urandom);
      end
      nbytes = (b == nb - 1) ? L - 8 * b : 8;
      send_beat(d, b == nb - 1, nbytes);
    end
  endtask

  task automatic wait_valid(input string nm);
    int g;
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clock);
      #1;
      g++;
    end
    chk(nm, out_valid, 1'b1);
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(posedge clock);
      #1;
      g++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_length"}, out_length, 0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk_blk({tag, "_out_block"}, out_block, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Random out_ready, a little after the edge so directed overrides do not race.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rdy_mode == 0) out_ready = (($urandom % 4) != 0);
    end
  end

  // Compare process: every cycle in_ready must be the inverse of out_valid;
  // a stalled block must hold; every handshake must match the model.
  logic          stalled = 1'b0;
  logic [1087:0] p_blk;
  logic [10:0]   p_len;
  logic          p_last;
  blk_t          e;

  always @(negedge clock) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      chk("in_ready_vs_out_valid", in_ready, !out_valid);
      if (out_valid) begin
        if (stalled) begin
          chk_blk("hold_block", out_block, p_blk);
          chk("hold_length", out_length, p_len);
          chk("hold_last", out_last, p_last);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_block: got length %0d, expected no block", out_length);
          end else begin
            e = exp_q.pop_front();
            chk_blk("block", out_block, e.data);
            chk("length", out_length, e.len);
            chk("last", out_last, e.last);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          p_blk   = out_block;
          p_len   = out_length;
          p_last  = out_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    bq_t m;
    int unsigned L;
    logic [63:0] d;

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bytes  = '0;
    out_ready = 1'b0;

    // Pin the model against hand-derived block splits.
    model(make_const(0, 8'h00));
    chk("model_empty_count", mdl_q.size(), 1);
    chk("model_empty_len", mdl_q[0].len, 0);
    chk("model_empty_last", mdl_q[0].last, 1'b1);
    model(make_const(200, 8'hA3));
    chk("model_200_count", mdl_q.size(), 2);
    chk("model_200_len0", mdl_q[0].len, 1088);
    chk("model_200_last0", mdl_q[0].last, 1'b0);
    chk_blk("model_200_data0", mdl_q[0].data, {136{8'hA3}});
    chk("model_200_len1", mdl_q[1].len, 512);
    chk("model_200_last1", mdl_q[1].last, 1'b1);
    chk_blk("model_200_data1", mdl_q[1].data, {{64{8'hA3}}, 576'h0});
    model(make_const(136, 8'h5C));
    chk("model_136_count", mdl_q.size(), 2);
    chk("model_136_len1", mdl_q[1].len, 0);
    chk("model_136_last1", mdl_q[1].last, 1'b1);
    m = {8'h01, 8'h02, 8'h03};
    model(m);
    chk("model_3_len", mdl_q[0].len, 24);
    chk("model_3_bytes", mdl_q[0].data[1087 -: 24], 24'h010203);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_length", out_length, 0);
    chk("reset_out_last", out_last, 1'b0);
    chk_blk("reset_out_block", out_block, '0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    rdy_mode = 0;

    send_msg(make_const(0, 8'h00));
    send_msg(make_const(64, 8'hA3));
    send_msg(make_const(200, 8'hA3));
    send_msg(make_rand(136));
    drain("drain_directed");

    // Backpressure: hold the block for 10 cycles, then release it.
    rdy_mode  = 1;
    out_ready = 1'b0;
    send_msg(make_rand(64));
    wait_valid("bp_out_valid");
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    drain("drain_backpressure");

    // Reset in the middle of a 17-beat message.
    rdy_mode = 0;
    for (int unsigned b = 0; b < 5; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, 1'b0, 8);
    end
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("rst_mid_msg");
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_msg(m);
    drain("drain_after_reset");

    // Reset while a block is being held in EMIT.
    rdy_mode  = 1;
    out_ready = 1'b0;
    send_msg(make_rand(100));
    wait_valid("emit_out_valid");
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_outputs_zero("rst_mid_emit");
    @(posedge clock);
    #1;
    reset    = 1'b0;
    rdy_mode = 0;

    for (int unsigned t = 0; t < 30; t++) begin
      case ($urandom % 4)
        0:       L = $urandom_range(0, 300);
        1:       L = 136 * $urandom_range(1, 2) + $urandom_range(0, 2) - 1;
        2:       L = $urandom_range(0, 16);
        default: L = 8 * $urandom_range(0, 34);
      endcase
      send_msg(make_rand(L));
    end
    drain("drain_random");

    finish_run();
  end

endmodule
